// File: rtl/fp16_seq_pkg.sv
// Shared types and constants for the fp16 calculator front-end sequencer.
`timescale 1ns/1ps
package fp16_seq_pkg;

  // Sequencer states; the encoding is visible on state_out.
  typedef enum logic [2:0] {
    ST_LOAD_A1 = 3'd0,
    ST_LOAD_A2 = 3'd1,
    ST_LOAD_B1 = 3'd2,
    ST_LOAD_B2 = 3'd3,
    ST_START   = 3'd4,
    ST_WAIT    = 3'd5,
    ST_SHOW    = 3'd6,
    ST_ERR     = 3'd7
  } state_t;

  // Result shown when the datapath never answers.
  localparam logic [15:0] FP16_QNAN = 16'h7E00;

  // Operation codes understood by the arithmetic unit.
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, consecutive-sample debouncer and rising-edge press pulse.
`timescale 1ns/1ps
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync_1;
  logic          sync_2;
  logic          level;
  logic          level_prev;
  logic [CW-1:0] cnt;

  // Synchronize the raw button, then flip the level after enough differing samples.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      level      <= 1'b0;
      level_prev <= 1'b0;
      cnt        <= '0;
    end else begin
      sync_1     <= btn_raw;
      sync_2     <= sync_1;
      level_prev <= level;
      if (sync_2 != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync_2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  // One-cycle pulse on the debounced 0->1 transition; releases produce nothing.
  assign press = level & ~level_prev;

endmodule

// File: rtl/fp16_calc_sequencer.sv
// Operand load sequencer, start/done handshake with timeout, and result hold for the fp16 calculator.
`timescale 1ns/1ps
module fp16_calc_sequencer
  import fp16_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic [1:0]  op_in,
  input  logic        next_btn,
  input  logic        cancel_btn,
  output logic [15:0] calc_a,
  output logic [15:0] calc_b,
  output logic [1:0]  calc_op,
  output logic        calc_start,
  input  logic        calc_done,
  input  logic [15:0] calc_result,
  output logic [15:0] result_out,
  output logic [2:0]  state_out,
  output logic        busy,
  output logic        error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t        state;
  state_t        state_nx;
  logic          next_press;
  logic          cancel_press;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (next_btn),
    .press   (next_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel_db (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (cancel_btn),
    .press   (cancel_press)
  );

  // Counter holds the number of WAIT cycles already spent; the last allowed one is TIMEOUT_CYCLES-1.
  assign timeout_hit = (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_LOAD_A1;
    else       state <= state_nx;
  end

  // Next-state logic; cancel overrides everything, done beats timeout.
  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    state_nx = state;
    if (cancel_press) begin
      state_nx = ST_LOAD_A1;
    end else begin
      unique case (state)
        ST_LOAD_A1: if (next_press) state_nx = ST_LOAD_A2;
        ST_LOAD_A2: if (next_press) state_nx = ST_LOAD_B1;
        ST_LOAD_B1: if (next_press) state_nx = ST_LOAD_B2;
        ST_LOAD_B2: if (next_press) state_nx = ST_START;
        ST_START:   state_nx = ST_WAIT;
        ST_WAIT: begin
          if (calc_done)        state_nx = ST_SHOW;
          else if (timeout_hit) state_nx = ST_ERR;
        end
        ST_SHOW, ST_ERR: if (next_press) state_nx = ST_LOAD_A1;
        default: state_nx = ST_LOAD_A1;
      endcase
    end
  end

  // Moore outputs decoded from the current state.
  always_comb begin
    state_out  = state;
    calc_start = (state == ST_START);
    busy       = (state == ST_START) || (state == ST_WAIT);
    error      = (state == ST_ERR);
  end

  // Operand, op, result and timeout registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      calc_a     <= '0;
      calc_b     <= '0;
      calc_op    <= '0;
      result_out <= '0;
      to_cnt     <= '0;
    end else if (cancel_press) begin
      calc_a  <= '0;
      calc_b  <= '0;
      calc_op <= '0;
    end else begin
      case (state)
        ST_LOAD_A1: if (next_press) calc_a[15:8] <= data_in;
        ST_LOAD_A2: if (next_press) calc_a[7:0]  <= data_in;
        ST_LOAD_B1: if (next_press) calc_b[15:8] <= data_in;
        ST_LOAD_B2: begin
          // op is captured on the edge that enters START so it is valid during the start pulse.
          if (next_press) begin
            calc_b[7:0] <= data_in;
            calc_op     <= op_in;
          end
        end
        ST_START: to_cnt <= '0;
        ST_WAIT: begin
          if (calc_done)        result_out <= calc_result;
          else if (timeout_hit) result_out <= FP16_QNAN;
          else                  to_cnt     <= to_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/fp16_calc_sequencer.md
# fp16_calc_sequencer

Front-end controller for the fp16 calculator datapath. It turns a single debounced NEXT button and an 8-bit switch bank into the four-byte operand load sequence (A high, A low, B high, B low). It then issues a one-cycle start to the calculator, waits for its done strobe under a timeout, and holds the result for the LEDs. A CANCEL button aborts the sequence at any point. It sits between the board I/O and the fp16 arithmetic unit.

## Interface
- DEBOUNCE_CYCLES, 16, consecutive stable synchronized samples required to change a debounced button level (board builds override with a large value)
- TIMEOUT_CYCLES, 64, maximum WAIT cycles before declaring a calculator fault
- clk  in  1  single system clock
- reset  in  1  synchronous, active-high; all registers take reset values on the clk edge where reset is 1
- data_in  in  8  switch byte, sampled on the clk edge of an accepted NEXT press
- op_in  in  2  operation select, latched on entry to START
- next_btn  in  1  raw asynchronous button, advance sequence
- cancel_btn  in  1  raw asynchronous button, abort to LOAD_A1
- calc_a  out  16  operand A register to datapath
- calc_b  out  16  operand B register to datapath
- calc_op  out  2  latched operation to datapath
- calc_start  out  1  one-cycle start pulse
- calc_done  in  1  datapath completion strobe
- calc_result  in  16  datapath result, valid with calc_done
- result_out  out  16  held result for LEDs
- state_out  out  3  current state encoding
- busy  out  1  high in START or WAIT
- error  out  1  high in ERR

## Operation
- Each button uses a 2-flop synchronizer and then a debouncer. The debounced level flips only after DEBOUNCE_CYCLES consecutive synchronized samples that differ from it. A press is a one-cycle pulse on the debounced 0→1 transition. Releases generate nothing.
- State encoding: LOAD_A1=0, LOAD_A2=1, LOAD_B1=2, LOAD_B2=3, START=4, WAIT=5, SHOW=6, ERR=7.
- LOAD_A1: on a NEXT press, calc_a[15:8]←data_in, then go to LOAD_A2.
- LOAD_A2: on a NEXT press, calc_a[7:0]←data_in, then go to LOAD_B1.
- LOAD_B1 and LOAD_B2 load calc_b the same way (high byte, then low byte). LOAD_B2 then goes to START.
- START: calc_op←op_in, calc_start=1 for exactly this cycle, then go to WAIT unconditionally. The timeout counter clears.
- WAIT: if calc_done=1, result_out←calc_result and go to SHOW. Otherwise the counter increments. After TIMEOUT_CYCLES WAIT cycles without done, result_out←16'h7E00 (fp16 qNaN) and go to ERR.
- SHOW and ERR: result_out is held. A NEXT press goes to LOAD_A1. Operands are not cleared and are overwritten by the next load.
- A CANCEL press in any state goes to LOAD_A1 on the next cycle and clears calc_a, calc_b and calc_op to 0. result_out is unchanged. Cancel during WAIT abandons the operation, and a later calc_done is ignored.
- NEXT presses in START or WAIT are dropped.
- calc_done outside WAIT is ignored.
- NEXT and CANCEL pressing in the same cycle: CANCEL wins.
- calc_done on the cycle the timeout would expire: done wins.
- calc_a, calc_b and calc_op are register outputs, stable from START through the end of WAIT.

## Timing
- Reset values: state LOAD_A1, calc_a=0, calc_b=0, calc_op=0, calc_start=0, result_out=0, busy=0, error=0. Synchronizers, debounced levels and counters are all 0.
- Press latency: raw button rises and is held from cycle t; the press pulse is at cycle t+2+DEBOUNCE_CYCLES. Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- A button held through reset release produces one press at DEBOUNCE_CYCLES+2 cycles after the first non-reset cycle.
- Press in LOAD_x at cycle p: byte register and state_out update visible at p+1.
- LOAD_B2 press at cycle p: START (calc_start=1) at p+1, WAIT at p+2.
- calc_done sampled high at WAIT cycle d: result_out valid and state SHOW at d+1.
- START at cycle s with no done: state ERR and result_out=7E00 at s+TIMEOUT_CYCLES+1. Done at cycle s+TIMEOUT_CYCLES is still accepted.

## Structure
- Package fp16_seq_pkg holds:
  - the state enum, 3-bit, with the encodings above
  - FP16_QNAN = 16'h7E00
  - the op code constants: 00 add, 01 sub, 10 mul, 11 div
- Sub-module btn_debounce (synchronizer, counter, level, press pulse), parameterized by DEBOUNCE_CYCLES and instantiated once per button.

## Test plan
- Normal flow (DEBOUNCE_CYCLES=4):
  - Stimulus: press NEXT with data_in 3C, 00, 40, 00; op_in=00. Stub asserts done 3 cycles after start with 4200.
  - Required response: calc_a=3C00, calc_b=4000, a single calc_start pulse, result_out=4200, state_out=6.
- Debounce:
  - A 3-cycle glitch on next_btn produces no state change.
  - A clean hold produces exactly one advance at t+6.
  - A long hold does not auto-repeat.
- Timeout (TIMEOUT_CYCLES=8):
  - Stub never asserts done.
  - Required response: ERR with error=1 and result_out=7E00 exactly 9 cycles after start. A NEXT press then gives LOAD_A1 with error=0.
- Cancel:
  - CANCEL in LOAD_B1 gives state 0, calc_a=0, and result_out unchanged.
  - CANCEL in WAIT followed by a late done gives result_out unchanged.
  - Simultaneous NEXT and CANCEL gives LOAD_A1.
- Boundaries:
  - calc_done on the last timeout cycle gives SHOW, not ERR.
  - calc_done in LOAD_A2 is ignored.
  - NEXT during WAIT is dropped.
- Reset mid-WAIT: all outputs return to their reset values on the next cycle, with no calc_start.
